// File: rtl/llc_update_seq_pkg.sv
// Shared LLC types: entry layout, state/hprot encodings, op kinds and controller states.
// Pure declarations; no latency or backpressure of its own.
// Imported by llc_update_seq and llc_flush_mask.
package llc_update_seq_pkg;

    localparam int TAG_W     = 16;
    localparam int LINE_W    = 32;
    localparam int OWNER_W   = 4;
    localparam int SHARERS_W = 16;

    typedef logic [1:0] llc_state_t;
    localparam llc_state_t INVALID = 2'd0;
    localparam llc_state_t VALID   = 2'd1;
    localparam llc_state_t SHARED  = 2'd2;
    localparam llc_state_t EXCL    = 2'd3;

    typedef logic hprot_t;
    localparam hprot_t INSTR = 1'b0;
    localparam hprot_t DATA  = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        llc_state_t           state;
        logic [LINE_W-1:0]    line;
        hprot_t               hprot;
        logic [OWNER_W-1:0]   owner;
        logic [SHARERS_W-1:0] sharers;
        logic                 dirty;
    } llc_entry_t;

    localparam logic [1:0] OP_UPDATE = 2'd0;
    localparam logic [1:0] OP_RST    = 2'd1;
    localparam logic [1:0] OP_FLUSH  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_UPD, S_RST_WR, S_FL_RD, S_FL_WR, S_DONE
    } seq_state_t;

    function automatic llc_entry_t invalid_entry();
        llc_entry_t e;
        e       = '0;
        e.state = INVALID;
        return e;
    endfunction

endpackage

// File: rtl/llc_update_seq_flush_mask.sv
// Per-way flush select: VALID DATA lines (and dirty ones only when LLC_UPDATE_FLUSH_DIRTY_EN is defined).
// Latency 0 (combinational).
// No backpressure.
module llc_flush_mask
    import llc_update_seq_pkg::*;
#(
    parameter int WAYS = 16
) (
    input  llc_state_t [WAYS-1:0] states_i,
    input  hprot_t     [WAYS-1:0] hprots_i,
    input  logic       [WAYS-1:0] dirty_i,
    output logic       [WAYS-1:0] mask_o
);

`ifdef LLC_UPDATE_FLUSH_DIRTY_EN
    localparam logic DIRTY_REQ = 1'b1;
`else
    localparam logic DIRTY_REQ = 1'b0;
`endif

    always_comb begin
        mask_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            mask_o[w] = (states_i[w] == VALID) && (hprots_i[w] == DATA) && (dirty_i[w] || !DIRTY_REQ);
        end
    end

endmodule

// File: rtl/llc_update_seq.sv
// LLC array write-back sequencer: single-entry updates, reset walk, flush walk (LLC_UPDATE_FLUSH_DIRTY_EN narrows flush to dirty lines).
// Latency: writes are registered, 1 cycle after accept / walk step; flush takes 2 cycles per set.
// Backpressure: op_ready only in IDLE/UPD; walk_stall freezes the walker; done held until done_ready.
module llc_update_seq
    import llc_update_seq_pkg::*;
#(
    parameter int  WAYS  = 16,
    parameter int  SETS  = 512,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_kind,
    input  logic [SET_W-1:0]      op_set,
    input  logic [WAY_W-1:0]      op_way,
    input  llc_entry_t            op_entry,
    input  logic [WAY_W-1:0]      op_evict_way,
    input  logic                  op_update_evict,
    input  logic                  walk_stall,
    output logic                  rd_en,
    output logic [SET_W-1:0]      rd_set,
    input  llc_state_t [WAYS-1:0] rd_states,
    input  hprot_t     [WAYS-1:0] rd_hprots,
    input  logic [WAYS-1:0]       rd_dirty,
    output logic                  wr_en,
    output logic [SET_W-1:0]      wr_set,
    output logic [WAYS-1:0]       wr_way_mask,
    output llc_entry_t            wr_entry,
    output logic                  wr_en_evict_way,
    output logic [WAY_W-1:0]      wr_evict_way,
    output logic                  busy,
    output logic                  done_valid,
    input  logic                  done_ready
);

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    seq_state_t       state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [SET_W-1:0] wr_set_q, wr_set_d;
    logic [WAYS-1:0]  wr_mask_q, wr_mask_d;
    llc_entry_t       wr_entry_q, wr_entry_d;
    logic             wr_ev_en_q, wr_ev_en_d;
    logic [WAY_W-1:0] wr_ev_q, wr_ev_d;
    logic [WAYS-1:0]  flush_mask;
    logic             accept;

    llc_flush_mask #(.WAYS(WAYS)) u_flush_mask (
        .states_i (rd_states),
        .hprots_i (rd_hprots),
        .dirty_i  (rd_dirty),
        .mask_o   (flush_mask)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_set_d   = wr_set_q;
        wr_mask_d  = '0;
        wr_entry_d = wr_entry_q;
        wr_ev_en_d = 1'b0;
        wr_ev_d    = wr_ev_q;
        op_ready   = (state_q == S_IDLE) || (state_q == S_UPD);
        accept     = op_valid && op_ready;
        rd_en      = 1'b0;
        done_valid = 1'b0;

        case (state_q)
            S_IDLE, S_UPD: begin
                state_d = S_IDLE;
                if (accept) begin
                    case (op_kind)
                        OP_UPDATE: begin
                            state_d    = S_UPD;
                            wr_en_d    = 1'b1;
                            wr_set_d   = op_set;
                            wr_mask_d  = WAYS'(1) << op_way;
                            wr_entry_d = op_entry;
                            wr_ev_en_d = op_update_evict;
                            wr_ev_d    = op_evict_way;
                        end
                        OP_RST: begin
                            state_d = S_RST_WR;
                            cnt_d   = '0;
                        end
                        OP_FLUSH: begin
                            state_d = S_FL_RD;
                            cnt_d   = '0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RST_WR: begin
                if (!walk_stall) begin
                    wr_en_d    = 1'b1;
                    wr_set_d   = cnt_q;
                    wr_mask_d  = '1;
                    wr_entry_d = invalid_entry();
                    wr_ev_en_d = 1'b1;
                    wr_ev_d    = '0;
                    if (cnt_q == LAST_SET) state_d = S_DONE;
                    else                   cnt_d   = cnt_q + SET_W'(1);
                end
            end
            S_FL_RD: begin
                if (!walk_stall) begin
                    rd_en   = 1'b1;
                    state_d = S_FL_WR;
                end
            end
            S_FL_WR: begin
                // A stall here invalidates the captured read, so go back and read again.
                if (walk_stall) begin
                    state_d = S_FL_RD;
                end else begin
                    wr_en_d    = |flush_mask;
                    wr_set_d   = cnt_q;
                    wr_mask_d  = flush_mask;
                    wr_entry_d = invalid_entry();
                    if (cnt_q == LAST_SET) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + SET_W'(1);
                        state_d = S_FL_RD;
                    end
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_set_q   <= '0;
            wr_mask_q  <= '0;
            wr_entry_q <= '0;
            wr_ev_en_q <= 1'b0;
            wr_ev_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_set_q   <= wr_set_d;
            wr_mask_q  <= wr_mask_d;
            wr_entry_q <= wr_entry_d;
            wr_ev_en_q <= wr_ev_en_d;
            wr_ev_q    <= wr_ev_d;
        end
    end

    assign rd_set          = cnt_q;
    assign wr_en           = wr_en_q;
    assign wr_set          = wr_set_q;
    assign wr_way_mask     = wr_mask_q;
    assign wr_entry        = wr_entry_q;
    assign wr_en_evict_way = wr_ev_en_q;
    assign wr_evict_way    = wr_ev_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: doc/llc_update_seq.md
Name: llc_update_seq

Overview:
- Sequential LLC array write-back controller, successor to the single-cycle LLC update logic.
- Owns three operations: single-entry updates, full-array reset walk, and flush walk; it also generates set addresses itself.
- Sits between the LLC core FSM and the tag/state/line/evict-way SRAM banks. Registered write outputs; valid/ready done handshake to the core.

Parameters:
- WAYS, 16, ways per set; power of two, ≥2.
- SETS, 512, sets in the LLC; power of two.
- WAY_W, $clog2(WAYS), derived way index width.
- SET_W, $clog2(SETS), derived set index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- op_valid  in  1  operation request
- op_ready  out  1  operation accepted when op_valid && op_ready
- op_kind  in  2  0=UPDATE, 1=RST, 2=FLUSH, 3=reserved (ignored, op_ready still asserted)
- op_set  in  SET_W  target set (UPDATE only)
- op_way  in  WAY_W  target way (UPDATE only)
- op_entry  in  llc_entry_t  full entry to write (UPDATE only)
- op_evict_way  in  WAY_W  new evict-way value
- op_update_evict  in  1  also write evict-way on UPDATE
- walk_stall  in  1  pauses walker, holding current set
- rd_en  out  1  read strobe for flush walk
- rd_set  out  SET_W  read set
- rd_states  in  WAYS x llc_state_t  state array data, valid 1 cycle after rd_en
- rd_hprots  in  WAYS x hprot_t  hprot data, same timing
- rd_dirty  in  WAYS  dirty bits, same timing (used only with feature)
- wr_en  out  1  array write strobe
- wr_set  out  SET_W  write set
- wr_way_mask  out  WAYS  per-way write enable
- wr_entry  out  llc_entry_t  write data
- wr_en_evict_way  out  1  evict-way array write
- wr_evict_way  out  WAY_W  evict-way data
- busy  out  1  state != IDLE
- done_valid  out  1  RST/FLUSH complete
- done_ready  in  1  core accepts done

Behaviour:
- Reset: async, active-high. state=IDLE, set counter=0. All outputs 0 except op_ready=1.
- States: IDLE, UPD, RST_WR, FL_RD, FL_WR, DONE.
- op_ready is 1 in IDLE and UPD, 0 otherwise.
- UPDATE accept → next cycle registered outputs:
  - wr_en=1, wr_set=op_set, wr_way_mask=onehot(op_way), wr_entry=op_entry.
  - wr_en_evict_way=op_update_evict, wr_evict_way=op_evict_way.
  - Latency 1 cycle; back-to-back UPDATEs give one write per cycle.
  - From UPD, return to IDLE if no new op is accepted.
- RST accept → RST_WR, counter=0. Each non-stalled cycle:
  - wr_en=1, wr_set=counter, wr_way_mask=all ones, wr_entry.state=INVALID, all other entry fields 0.
  - wr_en_evict_way=1, wr_evict_way=0.
  - counter+1.
  - After set SETS-1 is written → DONE. Total SETS cycles with no stall.
- FLUSH accept → FL_RD, counter=0.
  - FL_RD: rd_en=1, rd_set=counter → FL_WR.
  - FL_WR: sample rd_* data.
    - mask[w] = (state==VALID && hprot==DATA).
    - wr_en=|mask, wr_way_mask=mask, entry state INVALID, dirty 0, sharers 0. No evict-way write.
    - counter+1 → FL_RD, or → DONE after SETS-1. Total 2*SETS cycles.
- walk_stall=1: in RST_WR/FL_RD/FL_WR, no wr_en, no rd_en, counter and state held. In FL_WR the read data is re-sampled after the stall via a re-read (return to FL_RD).
- DONE: done_valid=1 held until done_ready; then → IDLE. done_valid is not asserted for UPDATE.
- Counter is SET_W bits and never wraps inside a walk; the terminal compare is on SETS-1.
- op_valid during a walk or DONE: no accept; the request is held by the core.
- rst mid-walk: immediate abort to IDLE, no done_valid; the core must reissue.

Optional Feature:
- LLC_UPDATE_FLUSH_DIRTY_EN defined: flush mask also requires rd_dirty[w]=1, so only dirty VALID DATA lines are written back/invalidated.
- Undefined: rd_dirty is ignored; mask = VALID && DATA.

Decomposition:
- Shared cache package holds:
  - llc_entry_t struct {tag, state, line, hprot, owner, sharers, dirty}.
  - llc_state_t, hprot_t, INVALID/VALID/DATA constants.
  - op_kind encoding constants.
- One natural sub-module, llc_flush_mask: combinational per-way mask generator, macro-sensitive.

Test Plan:
- WAYS=4, SETS=8: UPDATE set 3, way 2, op_update_evict=1, evict 1 → next cycle wr_en=1, wr_set=3, mask=0100, wr_en_evict_way=1, wr_evict_way=1.
- Three consecutive UPDATEs → three consecutive wr_en cycles, op_ready held 1.
- RST → 8 write cycles, sets 0..7, mask 1111, state INVALID, then done_valid; done_ready held 0 for 3 cycles keeps done_valid=1 and busy=1.
- FLUSH with set 5 states {V,I,V,V}, hprots {DATA,DATA,INSTR,DATA} → set 5 write mask 1001, other sets mask 0000 with wr_en=0; 16 cycles to DONE.
- walk_stall pulsed for 2 cycles at RST set 4 → no writes those cycles, set 4 written after, total 10 cycles.
- rst asserted at FLUSH set 2 → outputs zero same cycle, IDLE, op_ready=1, no done_valid.
- With LLC_UPDATE_FLUSH_DIRTY_EN and dirty 0001 in the set-5 case → mask 0001.
